uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Synchronous transmit FIFO directly upstream of the UART transmitter. The register interface writes bytes into it, and the transmitter drains them one word per completed frame. `empty` drives the transmitter's `tx_start` (inverted), `rd_data` drives its `data_in`, and its `tx_done` pulse pops the FIFO. The read port is first-word fall-through, so the head word is valid whenever `empty` is low.

## Interface
- `DBITS`, default 8: word width; must match the transmitter's `DBITS`.
- `ADDR_W`, default 4: address width; depth = 2^ADDR_W (16 entries).

- `clk_100MHz`, input, 1: system clock, all logic on its rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `wr`, input, 1: write strobe, one word per cycle high.
- `wr_data`, input, DBITS: word to enqueue, sampled with `wr`.
- `rd`, input, 1: pop strobe; connected to transmitter `tx_done`.
- `rd_data`, output, DBITS: head word, valid while `empty`=0.
- `empty`, output, 1: no words stored.
- `full`, output, 1: 2^ADDR_W words stored.
- `overflow`, output, 1: sticky flag, a write was dropped because the FIFO was full.
- `ovf_clr`, input, 1: synchronous clear of `overflow`.
- `count`, output, ADDR_W+1: occupancy 0..2^ADDR_W. Present only with `UART_TX_FIFO_COUNT_EN`.

## Operation
- Storage is a register array of 2^ADDR_W × DBITS, written on the clock edge at `wr_ptr` when a write is accepted. No reset of the array contents.
- Pointers `wr_ptr` and `rd_ptr` are ADDR_W bits wide and wrap naturally from 2^ADDR_W−1 to 0. `full` and `empty` are registered flags, not derived from pointer comparison at the output.
- `rd_data` = `mem[rd_ptr]`, combinational from storage (FWFT). It is undefined when `empty`=1.
- Per-cycle decisions on {`wr`, `rd`}:
  - 00: no change.
  - 01, not empty: `rd_ptr`+1; `full`←0; `empty`←1 if `rd_ptr`+1 == `wr_ptr`.
  - 01, empty: ignored, no state change (underflow is silent).
  - 10, not full: write, `wr_ptr`+1; `empty`←0; `full`←1 if `wr_ptr`+1 == `rd_ptr`.
  - 10, full: word dropped, pointers unchanged, `overflow`←1.
  - 11, neither flag set: write and pop; both pointers advance; flags unchanged.
  - 11, empty: write only. Treated as 10; the pop is ignored.
  - 11, full: write and pop both performed; `full` stays 1; no overflow.
- `overflow` is set by a dropped write and cleared by `ovf_clr`. If both happen in the same cycle, set wins.
- Reset, including mid-frame: pointers 0, `empty`=1, `full`=0, `overflow`=0, `count`=0. All stored words are discarded.

## Timing
- Write accepted at edge N: `empty` falls and `rd_data` is valid after edge N (cycle N+1). The transmitter sees `tx_start` one cycle after the write.
- Pop at edge N: the next head word is on `rd_data` and the flags are updated in cycle N+1. This matches the transmitter returning to idle one cycle after `tx_done`.
- All flags and `count` are registered. There are no combinational paths from `wr`/`rd` to any output.
- Throughput: one write and one read per cycle.

## Configuration
- `UART_TX_FIFO_COUNT_EN` defined: an ADDR_W+1-bit occupancy register exists.
  - Updates: +1 on an accepted write only; −1 on an accepted pop only; unchanged when both or neither are accepted.
  - `count` == 2^ADDR_W exactly when `full`=1.
- Not defined: the `count` port and its register are absent. All other behaviour is identical.

## Structure
- Shared package `uart_pkg`: default `DBITS`/`ADDR_W` constants and the {`wr`,`rd`} operation encoding used by the FIFO controller.
- Sub-module `uart_fifo_ctrl`: pointer, flag and count logic. It outputs `wr_ptr`, `rd_ptr`, `wr_en`, `full`, `empty`.
- The top level holds the storage array, the `overflow` flag, and the read mux.

## Test plan
- Reset, then write 0x41: `empty` goes 0 one cycle later and `rd_data`=0x41. Pulse `rd`: `empty`=1 next cycle.
- Write 16 words 0x00..0x0F: `full`=1 after the 16th write. Write 0xAA: `overflow`=1 and `full` stays set. Pop 16 words: `rd_data` sequence is 0x00..0x0F and 0xAA never appears.
- Fill to full, then `wr`=`rd`=1 with 0x55 in one cycle: `full` stays 1 and `rd_data` becomes 0x01. After 15 more pops the last word read is 0x55.
- Empty FIFO, `wr`=`rd`=1 with 0x33: word stored, `empty`=0, `rd_data`=0x33. `rd` alone on an empty FIFO changes nothing.
- Write 20 words, then pop 20 words in any interleaving: data order preserved across pointer wrap, and `count` (if enabled) tracks 0..16 correctly.
- Assert `reset` with 5 words stored while the transmitter is mid-frame: `empty`=1, `overflow`=0 and `count`=0 immediately (asynchronous).

Source files
------------

// File: rtl/uart_pkg.sv
//============================================================================
// Module      : uart_pkg
// Description : Shared constants and types for the UART transmit path.
//               Default word/address widths and the {wr, rd} operation
//               encoding decoded by the transmit FIFO controller.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none
`timescale 1ns/1ps

package uart_pkg;

    // Default word width; must match the transmitter's DBITS.
    localparam int DBITS_DEF  = 8;
    // Default FIFO address width (depth = 2**ADDR_W_DEF).
    localparam int ADDR_W_DEF = 4;

    // Per-cycle FIFO request, bit 1 = wr, bit 0 = rd.
    typedef enum logic [1:0] {
        OP_NONE  = 2'b00,
        OP_RD    = 2'b01,
        OP_WR    = 2'b10,
        OP_WR_RD = 2'b11
    } fifo_op_t;

    // Pack the two strobes into the operation encoding.
    function automatic fifo_op_t op_of(input logic wr, input logic rd);
        return fifo_op_t'({wr, rd});
    endfunction

endpackage : uart_pkg

`default_nettype wire

// File: rtl/uart_fifo_ctrl.sv
//============================================================================
// Module      : uart_fifo_ctrl
// Description : Pointer, flag and occupancy logic of the UART transmit FIFO.
//               Decides per cycle whether the write and the pop are accepted
//               and keeps registered full/empty flags.
//   clk_100MHz : system clock (rising edge)
//   reset      : asynchronous, active-high reset
//   wr, rd     : write / pop requests
//   wr_ptr     : storage address for an accepted write
//   rd_ptr     : address of the head word
//   wr_en      : write accepted this cycle (storage write enable)
//   full/empty : registered occupancy flags
//   count      : occupancy 0..2**ADDR_W, only when UART_TX_FIFO_COUNT_EN
//                is defined
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none
`timescale 1ns/1ps

module uart_fifo_ctrl
    import uart_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
)
(
    input  logic              clk_100MHz,
    input  logic              reset,
    input  logic              wr,
    input  logic              rd,
    output logic [ADDR_W-1:0] wr_ptr,
    output logic [ADDR_W-1:0] rd_ptr,
    output logic              wr_en,
    output logic              full,
    output logic              empty
`ifdef UART_TX_FIFO_COUNT_EN
    ,
    output logic [ADDR_W:0]   count
`endif
);

    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic              r_full;
    logic              r_empty;

    fifo_op_t          w_op;
    logic              w_wr_en;
    logic              w_rd_en;
    logic [ADDR_W-1:0] w_wr_ptr_nxt;
    logic [ADDR_W-1:0] w_rd_ptr_nxt;

    assign w_wr_ptr_nxt = r_wr_ptr + ADDR_W'(1);
    assign w_rd_ptr_nxt = r_rd_ptr + ADDR_W'(1);

    // Acceptance decode. A simultaneous write and pop on a full FIFO is
    // legal: the slot being vacated is the one being written. On an empty
    // FIFO the pop has nothing to remove, so only the write goes through.
    always_comb begin
        w_op    = op_of(wr, rd);
        w_wr_en = 1'b0;
        w_rd_en = 1'b0;
        case (w_op)
            OP_RD:    w_rd_en = ~r_empty;
            OP_WR:    w_wr_en = ~r_full;
            OP_WR_RD: begin
                w_wr_en = 1'b1;
                w_rd_en = ~r_empty;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_wr_en)
                r_wr_ptr <= w_wr_ptr_nxt;
            if (w_rd_en)
                r_rd_ptr <= w_rd_ptr_nxt;

            // Flags only move when occupancy changes; a balanced
            // write+pop leaves both where they are.
            if (w_wr_en && !w_rd_en) begin
                r_empty <= 1'b0;
                r_full  <= (w_wr_ptr_nxt == r_rd_ptr);
            end else if (w_rd_en && !w_wr_en) begin
                r_full  <= 1'b0;
                r_empty <= (w_rd_ptr_nxt == r_wr_ptr);
            end
        end
    end

`ifdef UART_TX_FIFO_COUNT_EN
    logic [ADDR_W:0] r_count;

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset)
            r_count <= '0;
        else if (w_wr_en && !w_rd_en)
            r_count <= r_count + (ADDR_W+1)'(1);
        else if (w_rd_en && !w_wr_en)
            r_count <= r_count - (ADDR_W+1)'(1);
    end

    assign count = r_count;
`endif

    assign wr_ptr = r_wr_ptr;
    assign rd_ptr = r_rd_ptr;
    assign wr_en  = w_wr_en;
    assign full   = r_full;
    assign empty  = r_empty;

endmodule : uart_fifo_ctrl

`default_nettype wire

// File: rtl/uart_tx_fifo.sv
//============================================================================
// Module      : uart_tx_fifo
// Description : First-word fall-through transmit FIFO feeding the UART
//               transmitter. The register interface writes bytes, the
//               transmitter's tx_done pulse pops them. The head word is on
//               rd_data whenever empty is low.
//   clk_100MHz : system clock (rising edge)
//   reset      : asynchronous, active-high reset; discards stored words
//   wr/wr_data : write strobe and word to enqueue
//   rd         : pop strobe (transmitter tx_done)
//   rd_data    : head word, valid while empty = 0
//   empty/full : registered occupancy flags
//   overflow   : sticky, a write was dropped while full
//   ovf_clr    : synchronous clear of overflow (a same-cycle drop wins)
//   count      : occupancy 0..2**ADDR_W, present only when the macro
//                UART_TX_FIFO_COUNT_EN is defined
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none
`timescale 1ns/1ps

module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DBITS  = DBITS_DEF,
    parameter int ADDR_W = ADDR_W_DEF
)
(
    input  logic             clk_100MHz,
    input  logic             reset,
    input  logic             wr,
    input  logic [DBITS-1:0] wr_data,
    input  logic             rd,
    output logic [DBITS-1:0] rd_data,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    input  logic             ovf_clr
`ifdef UART_TX_FIFO_COUNT_EN
    ,
    output logic [ADDR_W:0]  count
`endif
);

    localparam int c_depth = 2 ** ADDR_W;

    logic [DBITS-1:0]  r_mem [0:c_depth-1];
    logic              r_overflow;

    logic [ADDR_W-1:0] w_wr_ptr;
    logic [ADDR_W-1:0] w_rd_ptr;
    logic              w_wr_en;
    logic              w_drop;

    uart_fifo_ctrl #(
        .ADDR_W (ADDR_W)
    ) u_ctrl (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .wr         (wr),
        .rd         (rd),
        .wr_ptr     (w_wr_ptr),
        .rd_ptr     (w_rd_ptr),
        .wr_en      (w_wr_en),
        .full       (full),
        .empty      (empty)
`ifdef UART_TX_FIFO_COUNT_EN
        ,
        .count      (count)
`endif
    );

    // Storage is deliberately not reset; the flags make stale words
    // unreachable.
    always_ff @(posedge clk_100MHz) begin
        if (w_wr_en)
            r_mem[w_wr_ptr] <= wr_data;
    end

    // A requested write that the controller refused can only be a write
    // into a full FIFO without a matching pop.
    assign w_drop = wr & ~w_wr_en;

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset)
            r_overflow <= 1'b0;
        else if (w_drop)
            r_overflow <= 1'b1;
        else if (ovf_clr)
            r_overflow <= 1'b0;
    end

    assign overflow = r_overflow;
    assign rd_data  = r_mem[w_rd_ptr];

endmodule : uart_tx_fifo

`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
//============================================================================
// Module      : tb_uart_tx_fifo
// Description : Self-checking bench for uart_tx_fifo. Directed stimulus
//               pushes each accepted word into an expected-data queue; an
//               independent monitor pops and compares on every DUT pop.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_uart_tx_fifo;

    logic       clk_100MHz = 1'b0;
    logic       reset      = 1'b1;
    logic       wr         = 1'b0;
    logic [7:0] wr_data    = 8'h00;
    logic       rd         = 1'b0;
    logic       ovf_clr    = 1'b0;
    logic [7:0] rd_data;
    logic       empty;
    logic       full;
    logic       overflow;
`ifdef UART_TX_FIFO_COUNT_EN
    logic [4:0] count;
`endif

    int         n_checks = 0;
    int         n_errors = 0;
    int         m_cnt    = 0;
    logic [7:0] q_exp[$];

    uart_tx_fifo dut (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .wr         (wr),
        .wr_data    (wr_data),
        .rd         (rd),
        .rd_data    (rd_data),
        .empty      (empty),
        .full       (full),
        .overflow   (overflow),
        .ovf_clr    (ovf_clr)
`ifdef UART_TX_FIFO_COUNT_EN
        ,
        .count      (count)
`endif
    );

    always #5 clk_100MHz = ~clk_100MHz;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock of stimulus, driven just after a rising edge. The model
    // decides acceptance from its own occupancy count.
    task automatic cycle(input logic w, input logic [7:0] d, input logic r, input logic clr);
        logic wa;
        logic ra;
        wr      = w;
        wr_data = d;
        rd      = r;
        ovf_clr = clr;
        wa = w && ((m_cnt < 16) || r);
        ra = r && (m_cnt > 0);
        if (wa)
            q_exp.push_back(d);
        @(posedge clk_100MHz);
        m_cnt = m_cnt + int'(wa) - int'(ra);
        #1;
        wr      = 1'b0;
        rd      = 1'b0;
        ovf_clr = 1'b0;
    endtask

    // Monitor: every pop the DUT is about to perform must present the
    // oldest expected word.
    always @(negedge clk_100MHz) begin
        if (!reset && rd && !empty) begin
            if (q_exp.size() == 0)
                chk("pop_without_expected_word", 32'(rd_data), 32'hFFFF_FFFF);
            else
                chk("pop_data", 32'(rd_data), 32'(q_exp.pop_front()));
        end
`ifdef UART_TX_FIFO_COUNT_EN
        if (!reset)
            chk("count", 32'(count), 32'(m_cnt));
`endif
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(posedge clk_100MHz);
        #1 reset = 1'b0;

        // Reset state
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
`ifdef UART_TX_FIFO_COUNT_EN
        chk("rst_count", 32'(count), 32'd0);
`endif

        // Single word in and out
        cycle(1'b1, 8'h41, 1'b0, 1'b0);
        chk("w41_empty", 32'(empty), 32'd0);
        chk("w41_data", 32'(rd_data), 32'h41);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("p41_empty", 32'(empty), 32'd1);

        // Fill, overflow, drain
        for (int i = 0; i < 16; i++) begin
            chk("fill_not_full", 32'(full), 32'd0);
            cycle(1'b1, 8'(i), 1'b0, 1'b0);
        end
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_no_ovf", 32'(overflow), 32'd0);
        cycle(1'b1, 8'hAA, 1'b0, 1'b0);
        chk("drop_ovf", 32'(overflow), 32'd1);
        chk("drop_full", 32'(full), 32'd1);
        chk("drop_head", 32'(rd_data), 32'h00);
        for (int i = 0; i < 16; i++)
            cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("drain_empty", 32'(empty), 32'd1);
        chk("ovf_sticky", 32'(overflow), 32'd1);

        // Overflow clear, then set-wins-over-clear
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        chk("ovf_clr", 32'(overflow), 32'd0);
        for (int i = 0; i < 16; i++)
            cycle(1'b1, 8'(i), 1'b0, 1'b0);
        cycle(1'b1, 8'hEE, 1'b0, 1'b1);
        chk("ovf_set_wins", 32'(overflow), 32'd1);

        // Simultaneous write and pop while full
        cycle(1'b1, 8'h55, 1'b1, 1'b0);
        chk("full_wr_rd_full", 32'(full), 32'd1);
        chk("full_wr_rd_head", 32'(rd_data), 32'h01);
        chk("full_wr_rd_ovf", 32'(overflow), 32'd1);
        for (int i = 0; i < 15; i++)
            cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("last_word_55", 32'(rd_data), 32'h55);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("after55_empty", 32'(empty), 32'd1);

        // Simultaneous write and pop while empty, then underflow
        cycle(1'b1, 8'h33, 1'b1, 1'b0);
        chk("empty_wr_rd_empty", 32'(empty), 32'd0);
        chk("empty_wr_rd_data", 32'(rd_data), 32'h33);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("underflow_empty", 32'(empty), 32'd1);
        chk("underflow_full", 32'(full), 32'd0);
        cycle(1'b1, 8'h77, 1'b0, 1'b0);
        chk("post_underflow_data", 32'(rd_data), 32'h77);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // 20 words across pointer wrap, interleaved
        for (int i = 0; i < 12; i++)
            cycle(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
        for (int i = 12; i < 20; i++)
            cycle(1'b1, 8'(8'hC0 + i), 1'b1, 1'b0);
        chk("wrap_head", 32'(rd_data), 32'hC8);
        chk("wrap_not_full", 32'(full), 32'd0);
        for (int i = 0; i < 12; i++)
            cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("wrap_empty", 32'(empty), 32'd1);

        // Asynchronous reset with words stored and overflow set
        for (int i = 1; i <= 5; i++)
            cycle(1'b1, 8'(i), 1'b0, 1'b0);
        chk("pre_rst_ovf", 32'(overflow), 32'd1);
        chk("pre_rst_empty", 32'(empty), 32'd0);
        reset = 1'b1;
        #1;
        chk("arst_empty", 32'(empty), 32'd1);
        chk("arst_full", 32'(full), 32'd0);
        chk("arst_ovf", 32'(overflow), 32'd0);
`ifdef UART_TX_FIFO_COUNT_EN
        chk("arst_count", 32'(count), 32'd0);
`endif
        q_exp.delete();
        m_cnt = 0;
        @(posedge clk_100MHz);
        #1 reset = 1'b0;
        cycle(1'b1, 8'h12, 1'b0, 1'b0);
        chk("post_rst_data", 32'(rd_data), 32'h12);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("post_rst_empty", 32'(empty), 32'd1);

        repeat (2) @(posedge clk_100MHz);
        chk("queue_drained", 32'(q_exp.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_uart_tx_fifo

`default_nettype wire
